// File: rtl/hazard_scoreboard_pkg.sv
// Shared ISA codes and scoreboard definitions for the issue-hazard logic.
// Opcode/func values follow the MIPS-I encoding used by the decoder.
package hazard_scoreboard_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes, instr[5:0]
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // Link register written by JAL
  localparam logic [4:0] REG_RA     = 5'd31;

  // Maximum number of instructions allowed between issue and writeback
  localparam logic [2:0] MAX_INFLIGHT = 3'd4;

  // Issue-control FSM encoding (visible on the state output)
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BRANCH = 2'd2
  } state_t;

  // Destination register as produced by the decoder
  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } dest_t;

  // Memory-class opcodes that write their rt field
  function automatic logic writes_rt_mem(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_LB) ||
           (opcode == OP_LBU) || (opcode == OP_LUI);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_dest_decode.sv
// Combinational destination-register derivation for one decoded instruction.
// Returns valid=0 when the instruction writes no register or writes r0.
module dest_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0] i_instr_32,
  input  logic        i_alu_op,
  input  logic        i_mem_op,
  input  logic        i_branch_op,
  input  logic [4:0]  i_rt_addr_5,
  input  logic [4:0]  i_rd_addr_5,
  output logic        o_dest_valid,
  output logic [4:0]  o_dest_addr
);

  logic [5:0] w_opcode;
  logic [5:0] w_func;
  logic       w_special;
  dest_t      w_raw;

  // Register fields arrive on dedicated ports; only opcode/func are used here.
  logic w_unused_fields;
  assign w_unused_fields = ^i_instr_32[25:6];

  assign w_opcode  = i_instr_32[31:26];
  assign w_func    = i_instr_32[5:0];
  assign w_special = (w_opcode == OP_SPECIAL);

  // Pick the written register from class flags and opcode/func, in priority order
  always_comb begin
    w_raw = '0;
    if (w_special && i_alu_op) begin
      w_raw = '{valid: 1'b1, addr: i_rd_addr_5};
    end else if (w_special && i_mem_op && (w_func == FN_JALR)) begin
      w_raw = '{valid: 1'b1, addr: i_rd_addr_5};
    end else if (!w_special && i_alu_op) begin
      w_raw = '{valid: 1'b1, addr: i_rt_addr_5};
    end else if (i_mem_op && writes_rt_mem(w_opcode)) begin
      w_raw = '{valid: 1'b1, addr: i_rt_addr_5};
    end else if (i_branch_op && (w_opcode == OP_JAL)) begin
      w_raw = '{valid: 1'b1, addr: REG_RA};
    end
  end

  // r0 is hard-wired, so writing it is the same as writing nothing
  assign o_dest_valid = w_raw.valid && (w_raw.addr != 5'd0);
  assign o_dest_addr  = o_dest_valid ? w_raw.addr : 5'd0;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: tracks pending register writes, the
// number of in-flight instructions and an outstanding branch, and holds the
// presented instruction whenever any of them blocks it.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        w_dec_valid,
  input  logic [31:0] w_instr_32,
  input  logic        w_alu_op,
  input  logic        w_mem_op,
  input  logic        w_branch_op,
  input  logic        w_nop,
  input  logic [4:0]  w_rs_addr_5,
  input  logic [4:0]  w_rt_addr_5,
  input  logic [4:0]  w_rd_addr_5,
  input  logic        w_wb_valid,
  input  logic [4:0]  w_wb_addr_5,
  input  logic        w_br_done,
  input  logic        w_flush,
  output logic        w_issue,
  output logic        w_stall,
  output logic [31:0] w_busy_32,
  output logic [2:0]  w_inflight_3,
  output logic [1:0]  w_state_2,
  output logic        w_err
);

  logic [31:0] r_busy;
  logic [2:0]  r_inflight;
  logic        r_err;
  state_t      r_state;
  state_t      w_state_next;

  logic        w_dest_valid;
  logic [4:0]  w_dest_addr;

  logic        w_busy_rs;
  logic        w_busy_rt;
  logic        w_busy_dest;
  logic        w_hazard;
  logic        w_issue_op;
  logic        w_branch_issue;
  logic        w_wb_count;
  logic        w_underflow;
  logic [2:0]  w_inflight_next;
  logic [31:0] w_set_vec;
  logic [31:0] w_clr_vec;

  dest_decode u_dest_decode (
    .i_instr_32   (w_instr_32),
    .i_alu_op     (w_alu_op),
    .i_mem_op     (w_mem_op),
    .i_branch_op  (w_branch_op),
    .i_rt_addr_5  (w_rt_addr_5),
    .i_rd_addr_5  (w_rd_addr_5),
    .o_dest_valid (w_dest_valid),
    .o_dest_addr  (w_dest_addr)
  );

  // Hazard detection from registered state only; a writeback in the same
  // cycle is deliberately not bypassed, so the issue lands one cycle later.
  always_comb begin
    w_busy_rs      = (w_rs_addr_5 != 5'd0) && r_busy[w_rs_addr_5];
    w_busy_rt      = (w_rt_addr_5 != 5'd0) && r_busy[w_rt_addr_5];
    w_busy_dest    = w_dest_valid && r_busy[w_dest_addr];
    w_hazard       = w_busy_rs || w_busy_rt || w_busy_dest ||
                     (r_inflight == MAX_INFLIGHT) || (r_state == S_BRANCH);
    w_stall        = w_dec_valid & ~w_nop & w_hazard;
    w_issue        = w_dec_valid & ~w_stall & ~w_flush & ~reset;
    // A nop is accepted but is invisible to every piece of tracked state
    w_issue_op     = w_issue & ~w_nop;
    w_branch_issue = w_issue_op & w_branch_op;
  end

  // In-flight count update; a writeback with nothing in flight is an error
  always_comb begin
    w_wb_count      = w_wb_valid && (r_inflight != 3'd0);
    w_underflow     = w_wb_valid && (r_inflight == 3'd0);
    w_inflight_next = r_inflight;
    if (w_issue_op && !w_wb_count) begin
      w_inflight_next = r_inflight + 3'd1;
    end else if (!w_issue_op && w_wb_count) begin
      w_inflight_next = r_inflight - 3'd1;
    end
  end

  // Per-register set/clear strobes; r0 is never tracked
  assign w_set_vec[0] = 1'b0;
  assign w_clr_vec[0] = 1'b0;

  genvar gi;
  for (gi = 1; gi < 32; gi++) begin : g_busy_bit
    assign w_set_vec[gi] = w_issue_op && w_dest_valid && (w_dest_addr == 5'(gi));
    assign w_clr_vec[gi] = w_wb_valid && (w_wb_addr_5 == 5'(gi));
  end

  // Issue-control FSM next state; br_done only matters while a branch is open
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_branch_issue) begin
          w_state_next = S_BRANCH;
        end else if (w_issue_op) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_branch_issue) begin
          w_state_next = S_BRANCH;
        end else if (!w_issue_op && (w_inflight_next == 3'd0)) begin
          w_state_next = S_IDLE;
        end
      end
      S_BRANCH: begin
        if (w_br_done || w_flush) begin
          w_state_next = (w_inflight_next != 3'd0) ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In-flight counter and sticky underflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 3'd0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      r_err      <= r_err | w_underflow;
    end
  end

  // Pending-write vector; a set on the same register as a clear wins
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
    end
  end

  assign w_busy_32    = r_busy;
  assign w_inflight_3 = r_inflight;
  assign w_state_2    = r_state;
  assign w_err        = r_err;

endmodule
